// File: rtl/acondicionador_botones.sv
// Button front-end: pin polarity normalisation, 2-flop sync and debounce per channel,
// then press pulses (Energia/Medicina), long-press pulse (Reset) and long-press toggle (Test).
module acondicionador_botones #(
   parameter int DEBOUNCE_CYC   = 4,
   parameter int HOLD_RESET_CYC = 20,
   parameter int HOLD_TEST_CYC  = 10,
   parameter bit BTN_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_test,
   input  logic       btn_reset,
   input  logic       btn_energia,
   input  logic       btn_medicina,
   output logic       Bot_Test,
   output logic       Bot_Reset,
   output logic       Bot_Energia,
   output logic       Bot_Medicina,
   output logic [3:0] Estado_Botones
);
   localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
   localparam int RW = $clog2(HOLD_RESET_CYC + 1);
   localparam int TW = $clog2(HOLD_TEST_CYC + 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [RW-1:0] RST_LAST = RW'(HOLD_RESET_CYC - 1);
   localparam logic [RW-1:0] RST_SAT  = RW'(HOLD_RESET_CYC);
   localparam logic [TW-1:0] TST_LAST = TW'(HOLD_TEST_CYC - 1);
   localparam logic [TW-1:0] TST_SAT  = TW'(HOLD_TEST_CYC);

   // Channel order everywhere: [3]=test, [2]=reset, [1]=energia, [0]=medicina.
   logic [3:0]    w_raw;
   logic [3:0]    w_pressed;
   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    r_stable;
   logic [3:0]    r_stable_d;
   logic [DW-1:0] r_db_cnt [4];
   logic          r_bot_energia;
   logic          r_bot_medicina;
   logic [RW-1:0] r_hold_rst;
   logic          r_fired_rst;
   logic          r_bot_reset;
   logic [TW-1:0] r_hold_tst;
   logic          r_fired_tst;
   logic          r_bot_test;

   assign w_raw     = {btn_test, btn_reset, btn_energia, btn_medicina};
   assign w_pressed = BTN_ACTIVE_LOW ? ~w_raw : w_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_pressed;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable <= '0;
         for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_stable[i] <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stable_d     <= '0;
         r_bot_energia  <= 1'b0;
         r_bot_medicina <= 1'b0;
      end else begin
         r_stable_d     <= r_stable;
         r_bot_energia  <= r_stable[1] & ~r_stable_d[1];
         r_bot_medicina <= r_stable[0] & ~r_stable_d[0];
      end
   end

   // The event fires on the edge where the counter reaches the hold length; the fired
   // flag keeps a saturated counter from firing again until the button is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_rst  <= '0;
         r_fired_rst <= 1'b0;
         r_bot_reset <= 1'b0;
      end else if (!r_stable[2]) begin
         r_hold_rst  <= '0;
         r_fired_rst <= 1'b0;
         r_bot_reset <= 1'b0;
      end else begin
         r_bot_reset <= 1'b0;
         if (r_hold_rst != RST_SAT) r_hold_rst <= r_hold_rst + RW'(1);
         if (r_hold_rst == RST_LAST && !r_fired_rst) begin
            r_fired_rst <= 1'b1;
            r_bot_reset <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_tst  <= '0;
         r_fired_tst <= 1'b0;
         r_bot_test  <= 1'b0;
      end else if (!r_stable[3]) begin
         r_hold_tst  <= '0;
         r_fired_tst <= 1'b0;
      end else begin
         if (r_hold_tst != TST_SAT) r_hold_tst <= r_hold_tst + TW'(1);
         if (r_hold_tst == TST_LAST && !r_fired_tst) begin
            r_fired_tst <= 1'b1;
            r_bot_test  <= ~r_bot_test;
         end
      end
   end

   assign Bot_Test       = r_bot_test;
   assign Bot_Reset      = r_bot_reset;
   assign Bot_Energia    = r_bot_energia;
   assign Bot_Medicina   = r_bot_medicina;
   assign Estado_Botones = r_stable;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones at default parameters (active-low pins).
// Observed vector: {Bot_Test, Bot_Reset, Bot_Energia, Bot_Medicina, Estado_Botones}.
module tb_acondicionador_botones;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_test = 1'b1;
   logic       btn_reset = 1'b1;
   logic       btn_energia = 1'b1;
   logic       btn_medicina = 1'b1;
   logic       Bot_Test;
   logic       Bot_Reset;
   logic       Bot_Energia;
   logic       Bot_Medicina;
   logic [3:0] Estado_Botones;
   logic [7:0] w_obs;
   int         n_checks = 0;
   int         n_errors = 0;
   logic       exp_test;

   acondicionador_botones dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .btn_test       (btn_test),
      .btn_reset      (btn_reset),
      .btn_energia    (btn_energia),
      .btn_medicina   (btn_medicina),
      .Bot_Test       (Bot_Test),
      .Bot_Reset      (Bot_Reset),
      .Bot_Energia    (Bot_Energia),
      .Bot_Medicina   (Bot_Medicina),
      .Estado_Botones (Estado_Botones)
   );

   always #5 clk = ~clk;

   assign w_obs = {Bot_Test, Bot_Reset, Bot_Energia, Bot_Medicina, Estado_Botones};

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // p is the pressed mask {test,reset,energia,medicina}; pins are active-low.
   task automatic press(input logic [3:0] p);
      {btn_test, btn_reset, btn_energia, btn_medicina} = ~p;
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with every pin pressed, then idle after release.
      press(4'hF);
      rst_n = 1'b0;
      for (int k = 0; k < 5; k++) begin
         edge_step();
         check($sformatf("rst_hold k=%0d", k), w_obs, 8'h00);
      end
      press(4'h0);
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) begin
         edge_step();
         check($sformatf("idle k=%0d", k), w_obs, 8'h00);
      end

      // Clean energia press: stable from edge 5, pulse after edge 6 only.
      for (int k = 0; k < 40; k++) begin
         press(4'b0010);
         edge_step();
         check($sformatf("ene k=%0d", k), w_obs,
               {1'b0, 1'b0, (k == 6), 1'b0, 2'b00, (k >= 5), 1'b0});
      end
      for (int k = 0; k < 12; k++) begin
         press(4'b0000);
         edge_step();
         check($sformatf("ene_rel k=%0d", k), w_obs, {6'b0, (k < 5), 1'b0});
      end

      // Bouncy medicina: glitches at edges 3 and 6, final press from edge 7.
      for (int k = 0; k < 31; k++) begin
         press({3'b000, !(k == 3 || k == 6)});
         edge_step();
         check($sformatf("med k=%0d", k), w_obs,
               {1'b0, 1'b0, 1'b0, (k == 13), 3'b000, (k >= 12)});
      end
      for (int k = 0; k < 12; k++) begin
         press(4'b0000);
         edge_step();
         check($sformatf("med_rel k=%0d", k), w_obs, {7'b0, (k < 5)});
      end

      // Reset long press: pulse 20 edges after the debounced level rises.
      for (int k = 0; k < 30; k++) begin
         press(4'b0100);
         edge_step();
         check($sformatf("rst_long k=%0d", k), w_obs,
               {1'b0, (k == 25), 2'b00, 1'b0, (k >= 5), 2'b00});
      end
      for (int k = 0; k < 12; k++) begin
         press(4'b0000);
         edge_step();
         check($sformatf("rst_long_rel k=%0d", k), w_obs, {5'b0, (k < 5), 2'b00});
      end
      // Short reset press: 15 debounced cycles is under the hold time.
      for (int k = 0; k < 35; k++) begin
         press(k < 15 ? 4'b0100 : 4'b0000);
         edge_step();
         check($sformatf("rst_short k=%0d", k), w_obs,
               {5'b0, (k >= 5 && k < 20), 2'b00});
      end

      // Test toggle: two 15-cycle holds, then one 40-cycle hold.
      exp_test = 1'b0;
      for (int h = 0; h < 2; h++) begin
         for (int k = 0; k < 30; k++) begin
            press(k < 15 ? 4'b1000 : 4'b0000);
            edge_step();
            check($sformatf("tst%0d k=%0d", h, k), w_obs,
                  {(k >= 15) ? ~exp_test : exp_test, 3'b000, (k >= 5 && k < 20), 3'b000});
         end
         exp_test = ~exp_test;
      end
      for (int k = 0; k < 50; k++) begin
         press(k < 40 ? 4'b1000 : 4'b0000);
         edge_step();
         check($sformatf("tst_long k=%0d", k), w_obs,
               {(k >= 15), 3'b000, (k >= 5 && k < 45), 3'b000});
      end

      // All four together; Bot_Test starts at 1 and toggles back to 0.
      for (int k = 0; k < 30; k++) begin
         press(4'hF);
         edge_step();
         check($sformatf("all k=%0d", k), w_obs,
               {(k < 15), (k == 25), (k == 6), (k == 6), (k >= 5) ? 4'hF : 4'h0});
      end
      rst_n = 1'b0;
      #1;
      check("all_async_rst", w_obs, 8'h00);
      for (int k = 0; k < 3; k++) begin
         edge_step();
         check($sformatf("all_rst k=%0d", k), w_obs, 8'h00);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 35; k++) begin
         edge_step();
         check($sformatf("all_after k=%0d", k), w_obs,
               {(k >= 15), (k == 25), (k == 6), (k == 6), (k >= 5) ? 4'hF : 4'h0});
      end
      press(4'h0);
      repeat (10) edge_step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/acondicionador_botones.md
Name: acondicionador_botones

Overview:
Front-end that produces the button-side inputs of the pet mode logic (Bot_Test, Bot_Reset, Bot_Energia, Bot_Medicina) from raw board pushbuttons. Each channel is synchronised, debounced and converted into the event form the mode logic consumes:
- single-cycle press pulses for Energia and Medicina,
- a long-press pulse for Reset,
- a long-press toggled level for Test.

Sits between the board pins and the mode/state-machine block.

Parameters:
DEBOUNCE_CYC, 4, consecutive identical synchronised samples required to accept a new button level (>=2)
HOLD_RESET_CYC, 20, debounced-pressed cycles before Bot_Reset fires (board build: 5 s of clk)
HOLD_TEST_CYC, 10, debounced-pressed cycles before Bot_Test toggles
BTN_ACTIVE_LOW, 1, 1 = raw pins read 0 when pressed; 0 = read 1 when pressed

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn_test  input  1  raw test pushbutton (asynchronous to clk)
btn_reset  input  1  raw reset pushbutton
btn_energia  input  1  raw energy pushbutton
btn_medicina  input  1  raw medicine pushbutton
Bot_Test  output  1  test-mode level; toggles once per qualifying long press
Bot_Reset  output  1  one-cycle pulse per qualifying long press
Bot_Energia  output  1  one-cycle pulse per debounced press
Bot_Medicina  output  1  one-cycle pulse per debounced press
Estado_Botones  output  4  debounced pressed levels {test,reset,energia,medicina}, for LEDs/debug

Behaviour:
- Reset is asynchronous and active-low; one clock, clk. While rst_n=0, every output is 0: Bot_Test, Bot_Reset, Bot_Energia, Bot_Medicina and Estado_Botones=4'b0000. All synchronisers, counters and edge registers are also 0 ("released").
- Polarity: each raw pin is normalised to pressed=1 (inverted when BTN_ACTIVE_LOW=1) before the synchroniser.
- Synchroniser: 2 flops per channel; s = second-flop output.
- Debouncer, one per channel:
  - Holds a stable level and a counter cnt of width clog2(DEBOUNCE_CYC)+1.
  - If s==stable, cnt<=0.
  - Else if cnt==DEBOUNCE_CYC-1: stable<=s and cnt<=0.
  - Else cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes stable.
- Press pulse: registered on stable 0->1. The output is high for exactly 1 cycle.
- Press latency: first edge sampling the pin pressed = edge 0. stable rises at edge DEBOUNCE_CYC+1. Pulse high from edge DEBOUNCE_CYC+2 for one cycle (edge 6 at default).
- Release latency: the same DEBOUNCE_CYC+1 edges until stable falls. Release produces no pulse.
- Hold counters (Reset, Test):
  - Increment each cycle stable=1; saturate at HOLD_*_CYC.
  - Clear to 0 the cycle stable=0.
  - Reaching HOLD_*_CYC sets a fired flag. The flag clears only on release, giving exactly one event per press.
- Bot_Reset: high for the single cycle after the hold counter reaches HOLD_RESET_CYC.
- Bot_Test: inverts on the edge after the hold counter reaches HOLD_TEST_CYC; keeps its value otherwise.
- A press shorter than the hold time produces no Reset/Test event and no pulse on those channels.
- Energia/Medicina have no hold logic. Holding the button gives one pulse only; the next pulse requires a debounced release then a press.
- Channels are fully independent. Simultaneous presses yield simultaneous pulses with no priority or masking.
- rst_n asserted mid-press or mid-count:
  - all outputs drop immediately; a pending Bot_Test toggle is lost.
  - After rst_n release with the pin still held, the channel re-debounces from 0. A full hold time is required again.

Test Plan:
- Reset: rst_n=0 with all pins pressed -> all outputs 0 throughout. Release rst_n, no presses for 30 cycles -> outputs stay 0.
- Clean energia press (defaults, active-low pin driven 0 from edge 0, held 40 cycles) -> Bot_Energia=1 only in the cycle after edge 6; Estado_Botones[1]=1 from edge 5. Bot_Medicina stays 0.
- Bounce: medicina pin pressed for 3 cycles, released 1, pressed for 2, then held -> no pulse during the glitches. Exactly one Bot_Medicina pulse, DEBOUNCE_CYC+2 edges after the final stable press began.
- Reset long press: hold 30 cycles -> exactly one Bot_Reset pulse, 20 cycles after Estado_Botones[2] rises. Hold 15 cycles then release -> no pulse.
- Test toggle: two separate 15-cycle holds -> Bot_Test goes 0->1 after the first, 1->0 after the second. A 40-cycle hold toggles once only.
- All four pins pressed together and held 30 cycles:
  - Bot_Energia and Bot_Medicina pulse in the same cycle;
  - Bot_Test toggles;
  - Bot_Reset pulses.
  - Then rst_n pulsed low mid-hold -> everything returns to 0 and Reset re-fires 20 debounced cycles after release of rst_n.
